// File: rtl/fmul_classify_pipe.sv
// First FP-multiply stage: operand classification, special-case results,
// exponent sum and hidden-bit mantissas behind a 2-entry skid buffer.
module fmul_classify_pipe #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23,
  parameter int BIAS   = 127,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                RESET,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                a_sign,
  input  logic [EXP_W-1:0]    a_exp,
  input  logic [FRAC_W-1:0]   a_frac,
  input  logic                b_sign,
  input  logic [EXP_W-1:0]    b_exp,
  input  logic [FRAC_W-1:0]   b_frac,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_sign,
  output logic                out_primal,
  output logic                out_error,
  output logic [EXP_W-1:0]    out_exp,
  output logic [FRAC_W:0]     out_frac,
  output logic [EXP_W+1:0]    out_exp_sum,
  output logic [FRAC_W:0]     out_mant_a,
  output logic [FRAC_W:0]     out_mant_b,
  input  logic                err_clr,
  output logic                err_sticky,
  output logic [CNT_W-1:0]    err_count
);

  localparam int ES_W = EXP_W + 2;
  localparam int MW   = FRAC_W + 1;

  typedef struct packed {
    logic            sign;
    logic            primal;
    logic            error;
    logic [EXP_W-1:0] exp;
    logic [MW-1:0]   frac;
    logic [ES_W-1:0] exp_sum;
    logic [MW-1:0]   mant_a;
    logic [MW-1:0]   mant_b;
  } res_t;

  res_t new_d;
  res_t out_q, out_d;
  res_t skid_q, skid_d;
  logic out_v_q, out_v_d;
  logic skid_v_q, skid_v_d;
  logic sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic a_nan, a_inf, a_zero;
  logic b_nan, b_inf, b_zero;
  logic accept, out_free, xfer_err;

  assign a_nan  = (&a_exp) & (|a_frac);
  assign a_inf  = (&a_exp) & ~(|a_frac);
  assign a_zero = ~(|a_exp);
  assign b_nan  = (&b_exp) & (|b_frac);
  assign b_inf  = (&b_exp) & ~(|b_frac);
  assign b_zero = ~(|b_exp);

  always_comb begin
    new_d = '0;
    new_d.sign = a_sign ^ b_sign;
    new_d.primal = 1'b1;
    if (a_nan | b_nan | (a_inf & b_zero) | (a_zero & b_inf)) begin
      new_d.error = 1'b1;
      new_d.exp = '1;
      new_d.frac = {1'b1, {FRAC_W{1'b0}}};
    end else if (a_inf | b_inf) begin
      new_d.exp = '1;
    end else if (a_zero | b_zero) begin
      new_d.exp = '0;
    end else begin
      new_d.primal = 1'b0;
      new_d.exp_sum = {2'b00, a_exp} + {2'b00, b_exp} - ES_W'(BIAS);
      new_d.mant_a = {1'b1, a_frac};
      new_d.mant_b = {1'b1, b_frac};
    end
  end

  // in_ready only depends on skid occupancy, never on out_ready
  assign in_ready = ~skid_v_q & ~RESET;
  assign accept   = in_valid & in_ready;
  assign out_free = ~out_v_q | out_ready;

  always_comb begin
    out_d    = out_q;
    out_v_d  = out_v_q;
    skid_d   = skid_q;
    skid_v_d = skid_v_q;
    if (out_free) begin
      if (skid_v_q) begin
        out_d    = skid_q;
        out_v_d  = 1'b1;
        skid_v_d = 1'b0;
      end else begin
        out_v_d = accept;
        if (accept) out_d = new_d;
      end
    end else if (accept) begin
      skid_d   = new_d;
      skid_v_d = 1'b1;
    end
  end

  assign xfer_err = out_v_q & out_ready & out_q.error;

  always_comb begin
    sticky_d = xfer_err | (sticky_q & ~err_clr);
    cnt_d    = cnt_q;
    if (xfer_err && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      out_q    <= '0;
      out_v_q  <= 1'b0;
      skid_q   <= '0;
      skid_v_q <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      out_q    <= out_d;
      out_v_q  <= out_v_d;
      skid_q   <= skid_d;
      skid_v_q <= skid_v_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_valid   = out_v_q;
  assign out_sign    = out_q.sign;
  assign out_primal  = out_q.primal;
  assign out_error   = out_q.error;
  assign out_exp     = out_q.exp;
  assign out_frac    = out_q.frac;
  assign out_exp_sum = out_q.exp_sum;
  assign out_mant_a  = out_q.mant_a;
  assign out_mant_b  = out_q.mant_b;
  assign err_sticky  = sticky_q;
  assign err_count   = cnt_q;

endmodule
